// File: rtl/int8_mac_pkg.sv
// Shared widths, the packed-operand helpers and the result record for the dual INT8 MAC.
package int8_mac_pkg;

  localparam int MAX_LEN = 16;
  localparam int LW      = 16 + $clog2(MAX_LEN);
  localparam int AW      = 2 * LW;

  typedef struct packed {
    logic signed [LW-1:0] ac;
    logic signed [LW-1:0] bc;
    logic                 err;
  } mac_res_t;

  // a lands in the high field and b in the low field. A negative b borrows one from the high field.
  function automatic logic signed [AW-1:0] pack_ab(input logic signed [7:0] a,
                                                   input logic signed [7:0] b);
    logic signed [AW-1:0] a_ext;
    logic signed [AW-1:0] b_ext;
    a_ext = {{(AW-8){a[7]}}, a};
    b_ext = {{(AW-8){b[7]}}, b};
    return (a_ext <<< LW) + b_ext;
  endfunction

  // The low field is taken as signed. If it is negative, the high field has lost 1 and gets it back.
  function automatic mac_res_t unpack_acc(input logic signed [AW-1:0] acc);
    mac_res_t r;
    r.bc  = acc[LW-1:0];
    r.ac  = acc[AW-1:LW] + {{(LW-1){1'b0}}, acc[LW-1]};
    r.err = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/int8_dual_mac_unpack_out.sv
// Result register and valid/ready handshake. A new result may replace a result that is being taken on the same edge.
// Optional INT8_DUAL_MAC_CHECK_EN adds a registered mismatch flag next to the result.
module int8_dual_mac_unpack_out
  import int8_mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  mac_res_t             res_i,
`ifdef INT8_DUAL_MAC_CHECK_EN
  input  logic                 mismatch_i,
  output logic                 mismatch_o,
`endif
  input  logic                 m_ready_i,
  output logic                 m_valid_o,
  output logic signed [LW-1:0] ac_o,
  output logic signed [LW-1:0] bc_o,
  output logic                 err_o,
  output logic                 en_o
);

  logic     valid_q;
  logic     valid_d;
  mac_res_t res_q;

  // The whole pipeline freezes only while a held result is refused downstream.
  assign en_o = !(valid_q && !m_ready_i);

  always_comb begin
    // NOTE: default assignment first so no path leaves valid_d unassigned (no latch).
    valid_d = valid_q;
    if (load_i) begin
      valid_d = 1'b1;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) res_q <= res_i;
    end
  end

`ifdef INT8_DUAL_MAC_CHECK_EN
  logic mismatch_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (load_i) begin
      mismatch_q <= mismatch_i;
    end
  end
  assign mismatch_o = mismatch_q;
`endif

  assign m_valid_o = valid_q;
  assign ac_o      = res_q.ac;
  assign bc_o      = res_q.bc;
  assign err_o     = res_q.err;

endmodule

// File: rtl/int8_dual_mac_unpack.sv
// Streaming dual INT8 MAC: pack a and b, multiply by c, accumulate, then unpack sum(a*c) and sum(b*c).
// Optional INT8_DUAL_MAC_CHECK_EN adds direct reference accumulators and an m_mismatch output.
module int8_dual_mac_unpack
  import int8_mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [7:0]    s_a,
  input  logic signed [7:0]    s_b,
  input  logic signed [7:0]    s_c,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [LW-1:0] m_ac,
  output logic signed [LW-1:0] m_bc,
  output logic                 m_err
`ifdef INT8_DUAL_MAC_CHECK_EN
  ,
  output logic                 m_mismatch
`endif
);

  localparam int CW = $clog2(MAX_LEN);

  logic                 en;
  logic                 v1_q, last1_q;
  logic signed [AW-1:0] packed_q;
  logic signed [7:0]    c1_q;
  logic                 v2_q, last2_q;
  logic signed [AW-1:0] prod_q;
  logic                 v3_q, last3_q, err3_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 first, force_last, last_eff;
  logic signed [AW-1:0] c_ext;
  mac_res_t             res;
  logic                 load;

  assign s_ready = en;
  assign c_ext   = {{(AW-8){c1_q[7]}}, c1_q};

  // A zero beat count marks the first beat of a vector, both after reset and after any last beat.
  always_comb begin
    first      = (cnt_q == '0);
    force_last = (cnt_q == CW'(MAX_LEN - 1)) && !last2_q;
    last_eff   = last2_q || force_last;
    acc_d      = (first ? '0 : acc_q) + prod_q;
    cnt_d      = last_eff ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      packed_q <= '0;
      c1_q     <= '0;
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      prod_q   <= '0;
      v3_q     <= 1'b0;
      last3_q  <= 1'b0;
      err3_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (en) begin
      v1_q     <= s_valid;
      last1_q  <= s_last;
      packed_q <= pack_ab(s_a, s_b);
      c1_q     <= s_c;
      v2_q     <= v1_q;
      last2_q  <= last1_q;
      prod_q   <= packed_q * c_ext;
      v3_q     <= v2_q;
      if (v2_q) begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        last3_q <= last_eff;
        err3_q  <= force_last;
      end
    end
  end

  always_comb begin
    res     = unpack_acc(acc_q);
    res.err = err3_q;
  end

  assign load = en && v3_q && last3_q;

`ifdef INT8_DUAL_MAC_CHECK_EN
  // Reference sums are kept in separate LW-bit accumulators, so they do not depend on the packing.
  logic signed [7:0]    a1_q, b1_q;
  logic signed [LW-1:0] pac_q, pbc_q, ref_ac_q, ref_bc_q;
  logic signed [15:0]   pac_d, pbc_d;
  logic                 mismatch;

  assign pac_d    = a1_q * c1_q;
  assign pbc_d    = b1_q * c1_q;
  assign mismatch = (ref_ac_q != res.ac) || (ref_bc_q != res.bc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q     <= '0;
      b1_q     <= '0;
      pac_q    <= '0;
      pbc_q    <= '0;
      ref_ac_q <= '0;
      ref_bc_q <= '0;
    end else if (en) begin
      a1_q  <= s_a;
      b1_q  <= s_b;
      pac_q <= {{(LW-16){pac_d[15]}}, pac_d};
      pbc_q <= {{(LW-16){pbc_d[15]}}, pbc_d};
      if (v2_q) begin
        ref_ac_q <= (first ? '0 : ref_ac_q) + pac_q;
        ref_bc_q <= (first ? '0 : ref_bc_q) + pbc_q;
      end
    end
  end
`endif

  int8_dual_mac_unpack_out u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .res_i      (res),
`ifdef INT8_DUAL_MAC_CHECK_EN
    .mismatch_i (mismatch),
    .mismatch_o (m_mismatch),
`endif
    .m_ready_i  (m_ready),
    .m_valid_o  (m_valid),
    .ac_o       (m_ac),
    .bc_o       (m_bc),
    .err_o      (m_err),
    .en_o       (en)
  );

endmodule

// File: doc/int8_dual_mac_unpack.md
Name: int8_dual_mac_unpack

Overview:
- Streaming dual INT8 multiply-accumulate built on one shared wide multiplier per beat.
- Each beat packs operands a and b into one word, multiplies that word by c, and accumulates the packed product over a vector.
- On the last beat it splits the packed sum into the two signed results, sum(a*c) and sum(b*c), applying the borrow correction.
- Sits behind the INT8 operand fetch and feeds the requantisation stage over a valid/ready handshake.

Parameters:
- MAX_LEN, 16: maximum beats per vector; sets the guard bits.
- LW, 16+$clog2(MAX_LEN) (=20): width of each packed field and of each result.
- AW, 2*LW (=40): accumulator width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_a  in  8  signed operand a.
- s_b  in  8  signed operand b.
- s_c  in  8  signed shared multiplicand c.
- s_last  in  1  final beat of the vector.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accept.
- m_ac  out  LW  signed sum(a*c).
- m_bc  out  LW  signed sum(b*c).
- m_err  out  1  vector was truncated at MAX_LEN.

Behaviour:
- Reset values: m_valid=0, m_ac=0, m_bc=0, m_err=0. Accumulator, beat counter and pipeline valids are all cleared. Reset mid-vector discards partial sums; the first beat after reset starts a new vector.
- Stall rule: global enable en = !(m_valid && !m_ready), and s_ready = en. When en=0, every stage holds its contents.
- S1 (pack): registers packed = (s_a <<< LW) + sign-extended s_b, with AW width and signed arithmetic, plus c, last and valid.
- S2 (multiply): prod = packed * c, signed, truncated to AW bits.
- S3 (accumulate): acc_n = (first ? 0 : acc) + prod, where first is set after reset and after every last beat.
- Unpack from acc_n:
  - bc = acc_n[LW-1:0], signed.
  - ac = acc_n[AW-1:LW] + acc_n[LW-1], the borrow correction.
- Output register: on the S3 edge of a last beat, m_ac, m_bc and m_err load and m_valid is set.
- m_valid clears on m_valid && m_ready unless a new result loads on the same edge.
- Latency: a beat accepted at edge T produces its result with m_valid high after edge T+3. Full throughput is one beat per cycle, and back-to-back vectors have no bubble.
- Beat counter: counts S3 beats within the vector, 0..MAX_LEN-1.
  - If it reaches MAX_LEN-1 without last, that beat is forced to last and m_err=1.
  - The following beat starts a new vector.
- No overflow is possible within MAX_LEN: |a*c| ≤ 16384, so the sum fits in LW bits.
- Simultaneous m_ready and a new result: the new result replaces the old one; the old one counts as taken.
- A single-beat vector (s_last on the first beat) is legal.

Optional Feature:
- Macro INT8_DUAL_MAC_CHECK_EN.
- When defined:
  - Two independent LW-bit reference accumulators compute sum(a*c) and sum(b*c) directly, with an identical pipeline and stall behaviour.
  - Extra output port m_mismatch (1 bit, reset 0) is registered alongside m_ac and m_bc. It is 1 when either reference sum differs from the unpacked sum.
- When undefined: neither the port nor the logic exists, and behaviour is otherwise identical.

Decomposition:
- Package int8_mac_pkg holds:
  - localparam defaults for MAX_LEN, LW and AW.
  - Function pack_ab(a,b) returning AW bits.
  - Function unpack_acc(acc) returning a struct {ac, bc}.
  - typedef struct mac_res_t {logic signed [LW-1:0] ac, bc; logic err}.
- One natural sub-module: int8_dual_mac_unpack_out, the output register and handshake with the hold/replace logic.

Test Plan:
- Single beat a=-128, b=-128, c=-128, last=1 -> after 3 edges: m_ac=16384, m_bc=16384, m_err=0.
- 4 beats a=127, b=1, c=-1 -> m_ac=-508, m_bc=-4. This exercises the negative low-field borrow correction.
- 16 beats a=-128, b=-128, c=127, last on beat 16 -> m_ac=m_bc=-260096, m_err=0.
- 17 beats with a=1, b=2, c=3 and no last -> first result m_ac=48, m_bc=96, m_err=1. The 17th beat plus a following last beat forms a second vector.
- Back-to-back 1-beat vectors with m_ready held low 5 cycles -> s_ready drops while stalled, no result is lost or duplicated, and results appear in order.
- rst_n pulsed low mid-vector after 3 beats -> all outputs are 0. The next vector's result equals its own beats only.
